// File: rtl/sar_pkg.sv
// Shared definitions for the SAR unsigned-less-than search controller:
// state encoding, default width and the START-to-DONE latency.
package sar_pkg;

  localparam int SAR_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TEST   = 2'd1,
    SETTLE = 2'd2
  } sar_state_e;

  // Cycles from the START cycle to the DONE cycle. With settling, every
  // TRIAL load or update is followed by one dead cycle.
  function automatic int sar_latency(input int width, input bit settle);
    return settle ? (2 * width + 1) : (width + 1);
  endfunction

endpackage

// File: rtl/sar_ult_search_if.sv
// Handshake/data bundle between the SAR controller (master) and its
// environment: the requester plus the external ULT comparator (slave).
interface sar_ult_search_if #(parameter int WIDTH = 8);
  logic             START;
  logic             LT;
  logic [WIDTH-1:0] TRIAL;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] RESULT;

  modport master (input START, LT, output TRIAL, BUSY, DONE, RESULT);
  modport slave  (output START, LT, input TRIAL, BUSY, DONE, RESULT);
endinterface

// File: rtl/sar_bit_ptr.sv
// One-hot bit pointer for the SAR search: loads the MSB, walks one bit
// towards the LSB per shift, and flags when it sits on bit 0.
module sar_bit_ptr #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             load,
  input  logic             shift,
  output logic [WIDTH-1:0] ptr,
  output logic             last
);

  // Pointer register; load wins over shift.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ptr <= '0;
    end else if (load) begin
      ptr            <= '0;
      ptr[WIDTH-1]   <= 1'b1;
    end else if (shift) begin
      ptr <= ptr >> 1;
    end
  end

  assign last = ptr[0];

endmodule

// File: rtl/sar_ult_search.sv
// Successive-approximation controller driving the trial side of an external
// unsigned less-than comparator. Finds the largest code C with C <= X, one
// compare step per bit, using only bit set/clear operations.
// Build option: define SAR_SETTLE_EN to insert one SETTLE cycle after every
// TRIAL load/update, for comparators with a registered LT output.
module sar_ult_search
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESETN,
  sar_ult_search_if.master bus
);

  sar_state_e       state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] resolved;
  logic [WIDTH-1:0] ptr;
  logic             ptr_last;
  logic             ptr_load, ptr_shift;

  sar_bit_ptr #(.WIDTH(WIDTH)) u_ptr (
    .CLK    (CLK),
    .RESETN (RESETN),
    .load   (ptr_load),
    .shift  (ptr_shift),
    .ptr    (ptr),
    .last   (ptr_last)
  );

  // State and output registers; reset aborts any search without a DONE.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= IDLE;
      trial_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next state: resolve the current bit from LT, then arm the next one.
  always_comb begin
    state_d   = state_q;
    trial_d   = trial_q;
    result_d  = result_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ptr_load  = 1'b0;
    ptr_shift = 1'b0;
    resolved  = bus.LT ? (trial_q & ~ptr) : trial_q;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          trial_d          = '0;
          trial_d[WIDTH-1] = 1'b1;
          ptr_load         = 1'b1;
          busy_d           = 1'b1;
`ifdef SAR_SETTLE_EN
          state_d          = SETTLE;
`else
          state_d          = TEST;
`endif
        end
      end
      TEST: begin
        if (!ptr_last) begin
          trial_d   = resolved | (ptr >> 1);
          ptr_shift = 1'b1;
`ifdef SAR_SETTLE_EN
          state_d   = SETTLE;
`else
          state_d   = TEST;
`endif
        end else begin
          trial_d  = resolved;
          result_d = resolved;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
`ifdef SAR_SETTLE_EN
      // Comparator output is in flight; LT is not looked at here.
      SETTLE: state_d = TEST;
`endif
      default: state_d = IDLE;
    endcase
  end

  assign bus.TRIAL  = trial_q;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.RESULT = result_q;

endmodule

// File: tb/tb_sar_ult_search.sv
// Directed bench for sar_ult_search (WIDTH=8). Models the comparator as
// LT = X < TRIAL, registered when SAR_SETTLE_EN is defined.
module tb_sar_ult_search;

`ifdef SAR_SETTLE_EN
  localparam int LAT       = 17;
  localparam int STEP      = 2;
  localparam bit SETTLE_EN = 1'b1;
`else
  localparam int LAT       = 9;
  localparam int STEP      = 1;
  localparam bit SETTLE_EN = 1'b0;
`endif

  logic       CLK;
  logic       RESETN;
  logic [7:0] x;
  logic       glitch;
  int         checks;
  int         errors;

  sar_ult_search_if #(.WIDTH(8)) bus ();

  sar_ult_search #(.WIDTH(8)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

`ifdef SAR_SETTLE_EN
  logic lt_q;
  always @(posedge CLK) lt_q <= (x < bus.TRIAL);
  assign bus.LT = lt_q ^ glitch;
`else
  assign bus.LT = (x < bus.TRIAL) ^ glitch;
`endif

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // One search from the current cycle (cycle 0 = START high).
  task automatic do_search(input logic [7:0] xv, input logic [7:0] ev,
                           input string nm, input bit gl);
    int dc;
    dc = -1;
    x = xv;
    bus.START = 1'b1;
    for (int c = 1; c <= LAT + 4; c++) begin
      tick();
      if (c == 1) bus.START = 1'b0;
      glitch = gl && SETTLE_EN && (c % 2 == 1) && (c < LAT);
      checks++;
      if (bus.DONE === 1'b1 && dc >= 0) begin
        errors++;
        $display("FAIL %s extra_done: DONE high at cycle %0d, first at %0d", nm, c, dc);
      end
      if (bus.DONE === 1'b1 && dc < 0) dc = c;
    end
    glitch = 1'b0;
    checks++;
    if (dc !== LAT) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d expected %0d", nm, dc, LAT);
    end
    checks++;
    if (bus.RESULT !== ev) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", nm, bus.RESULT, ev);
    end
  endtask

  task automatic test_reset;
    RESETN = 1'b0;
    bus.START = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({bus.TRIAL, bus.RESULT, bus.BUSY, bus.DONE} !== 18'd0) begin
      errors++;
      $display("FAIL reset_state: TRIAL=%h RESULT=%h BUSY=%b DONE=%b expected all 0",
               bus.TRIAL, bus.RESULT, bus.BUSY, bus.DONE);
    end
    RESETN = 1'b1;
    tick();
  endtask

  task automatic test_main;
    logic [7:0] seq [8];
    int dc;
    seq = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};
    dc = -1;
    x = 8'h5A;
    bus.START = 1'b1;
    for (int c = 1; c <= LAT + 3; c++) begin
      tick();
      if (c == 1) bus.START = 1'b0;
      if (c < LAT) begin
        checks++;
        if (bus.TRIAL !== seq[(c - 1) / STEP]) begin
          errors++;
          $display("FAIL main_trial c%0d: got %h expected %h", c, bus.TRIAL, seq[(c - 1) / STEP]);
        end
      end
      if (c == 1) begin
        checks++;
        if (bus.BUSY !== 1'b1) begin
          errors++;
          $display("FAIL main_busy_start: got %b expected 1", bus.BUSY);
        end
      end
      if (bus.DONE === 1'b1 && dc < 0) begin
        dc = c;
        checks++;
        if (bus.BUSY !== 1'b0) begin
          errors++;
          $display("FAIL main_busy_done: got %b expected 0", bus.BUSY);
        end
      end
    end
    checks++;
    if (dc !== LAT) begin
      errors++;
      $display("FAIL main_done_cycle: got %0d expected %0d", dc, LAT);
    end
    checks++;
    if (bus.RESULT !== 8'h5A) begin
      errors++;
      $display("FAIL main_result: got %h expected 5a", bus.RESULT);
    end
  endtask

  task automatic test_boundaries;
    do_search(8'h00, 8'h00, "bound_x00", 1'b0);
    do_search(8'hFF, 8'hFF, "bound_xff", 1'b0);
    do_search(8'h80, 8'h80, "bound_x80", 1'b0);
  endtask

  task automatic test_back_to_back;
    int dc1, dc2;
    bit prev;
    dc1 = -1;
    dc2 = -1;
    prev = 1'b0;
    x = 8'h5A;
    bus.START = 1'b1;
    for (int c = 1; c <= 2 * LAT + 4; c++) begin
      tick();
      if (c == LAT + 1) bus.START = 1'b0;
      checks++;
      if (prev && bus.DONE === 1'b1) begin
        errors++;
        $display("FAIL b2b_done_width: DONE high two cycles at %0d", c);
      end
      prev = (bus.DONE === 1'b1);
      if (bus.DONE === 1'b1) begin
        if (dc1 < 0) begin
          dc1 = c;
          checks++;
          if (bus.RESULT !== 8'h5A) begin
            errors++;
            $display("FAIL b2b_result1: got %h expected 5a", bus.RESULT);
          end
          x = 8'hC3;
        end else if (dc2 < 0) begin
          dc2 = c;
        end
      end
    end
    checks++;
    if (dc1 !== LAT || dc2 !== 2 * LAT) begin
      errors++;
      $display("FAIL b2b_done_cycles: got %0d,%0d expected %0d,%0d", dc1, dc2, LAT, 2 * LAT);
    end
    checks++;
    if (bus.RESULT !== 8'hC3) begin
      errors++;
      $display("FAIL b2b_result2: got %h expected c3", bus.RESULT);
    end
  endtask

  task automatic test_busy_ignore;
    int dc, n;
    dc = -1;
    n = 0;
    x = 8'h3C;
    bus.START = 1'b1;
    for (int c = 1; c <= 2 * LAT + 2; c++) begin
      tick();
      if (c == 1 || c == 4) bus.START = 1'b0;
      if (c == 3) bus.START = 1'b1;
      if (bus.DONE === 1'b1) begin
        n++;
        if (dc < 0) dc = c;
      end
    end
    checks++;
    if (n !== 1 || dc !== LAT) begin
      errors++;
      $display("FAIL busy_ignore_done: got %0d pulses first at %0d expected 1 at %0d", n, dc, LAT);
    end
    checks++;
    if (bus.RESULT !== 8'h3C) begin
      errors++;
      $display("FAIL busy_ignore_result: got %h expected 3c", bus.RESULT);
    end
  endtask

  task automatic test_reset_abort;
    int n;
    n = 0;
    x = 8'h99;
    bus.START = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) bus.START = 1'b0;
    end
    RESETN = 1'b0;
    #1;
    checks++;
    if ({bus.TRIAL, bus.RESULT, bus.BUSY, bus.DONE} !== 18'd0) begin
      errors++;
      $display("FAIL abort_state: TRIAL=%h RESULT=%h BUSY=%b DONE=%b expected all 0",
               bus.TRIAL, bus.RESULT, bus.BUSY, bus.DONE);
    end
    tick();
    tick();
    RESETN = 1'b1;
    for (int c = 0; c < 2 * LAT; c++) begin
      tick();
      if (bus.DONE === 1'b1) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d pulses expected 0", n);
    end
    do_search(8'h77, 8'h77, "abort_recover", 1'b0);
  endtask

  task automatic test_settle_glitch;
    do_search(8'h33, 8'h33, "settle_x33", 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    x = 8'h00;
    glitch = 1'b0;
    test_reset();
    test_main();
    test_boundaries();
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
    test_settle_glitch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
